// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared types and width helpers for the temporal mux sequencer
package mux_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRST, RUN, DONE} state_e;
  localparam int MAX_VEC = 4096;
  function automatic int tw(input int width);
    return $clog2(width) + 1;
  endfunction
  function automatic int inf_of(input int width);
    return width;
  endfunction
  // Lane idx of a packed vector of w-bit times, zero-extended to 32 bits
  function automatic logic [31:0] lane_slice(input logic [MAX_VEC-1:0] vec, input int idx, input int w);
    return 32'(vec >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/mux_t_t_t_n_sched_tstamp_lane.sv
// tstamp_lane: one lane's latched spike time, event compare and first-edge stamp
module tstamp_lane
  import mux_sched_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  localparam int TW = tw(GAMMA_CYCLE_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] time_i,
  input  logic [TW-1:0] t_i,
  input  logic          run_i,
  input  logic          y_i,
  output logic          hi_o,
  output logic [TW-1:0] stamp_o
);
  localparam logic [TW-1:0] INF = TW'(inf_of(GAMMA_CYCLE_WIDTH));
  logic [TW-1:0] time_q, time_d, stamp_q, stamp_d;
  always_comb begin
    time_d  = load_i ? time_i : time_q;
    stamp_d = load_i ? INF : (run_i && y_i && stamp_q == INF) ? t_i : stamp_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q  <= INF;
      stamp_q <= INF;
    end else begin
      time_q  <= time_d;
      stamp_q <= stamp_d;
    end
  end
  // Times >= GAMMA_CYCLE_WIDTH never satisfy the compare, so such lanes stay low
  assign hi_o    = run_i && (time_q <= t_i);
  assign stamp_o = stamp_q;
endmodule

// File: rtl/mux_t_t_t_n_sched.sv
// mux_t_t_t_n_sched: gamma-cycle sequencer driving and timestamping an N-wide temporal mux
module mux_t_t_t_n_sched
  import mux_sched_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_INPUTS = GAMMA_CYCLE_WIDTH,
  parameter int GRST_CYCLES = 2,
  localparam int TW = tw(GAMMA_CYCLE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TW-1:0]            req_sel_time,
  input  logic [NUM_INPUTS*TW-1:0] req_in_times,
  output logic                     grst,
  output logic                     select_line,
  output logic [NUM_INPUTS-1:0]    mux_inputs,
  input  logic [NUM_INPUTS-1:0]    mux_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_INPUTS*TW-1:0] rsp_times,
  output logic                     busy
);
  localparam int GW = $clog2(GRST_CYCLES + 1);
  localparam logic [GW-1:0] GLAST = GW'(GRST_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  state_e state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] t_q, t_d, sel_q, sel_d;
  logic accept, run;
  assign accept = (state_q == IDLE) && req_valid;
  assign run    = (state_q == RUN);
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    t_d     = t_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = GRST;
        gcnt_d  = '0;
        sel_d   = req_sel_time;
      end
      GRST: if (gcnt_q == GLAST) begin
        state_d = RUN;
        t_d     = '0;
      end else gcnt_d = gcnt_q + GW'(1);
      RUN: if (t_q == TLAST) state_d = DONE;
        else t_d = t_q + TW'(1);
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      t_q     <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      t_q     <= t_d;
      sel_q   <= sel_d;
    end
  end
  // All outputs decode registered state; nothing passes combinationally from an input
  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign grst        = (state_q == IDLE) || (state_q == GRST);
  assign rsp_valid   = (state_q == DONE);
  assign select_line = run && (sel_q <= t_q);
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    tstamp_lane #(.GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (accept),
      .time_i  (TW'(lane_slice(MAX_VEC'(req_in_times), i, TW))),
      .t_i     (t_q),
      .run_i   (run),
      .y_i     (mux_y[i]),
      .hi_o    (mux_inputs[i]),
      .stamp_o (rsp_times[i*TW +: TW])
    );
  end
endmodule
